// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared constants for the multi-channel PWM controller.
// Register addresses, bus widths, default channel/counter widths and
// small helpers that map a channel index to its PERIOD/DUTY address.
package pwm_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_PRE_W = 20;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ADDR_CTRL     = 4'h0;
  localparam reg_addr_t ADDR_PRESCALE = 4'h1;
  localparam reg_addr_t ADDR_PER_BASE = 4'h2;
  localparam reg_addr_t ADDR_IRQ_STAT = 4'hA;
  localparam reg_addr_t ADDR_IRQ_EN   = 4'hB;

  // PERIOD_i lives at ADDR_PER_BASE + 2*i, DUTY_i right after it.
  function automatic reg_addr_t per_addr(input int unsigned ch);
    return ADDR_PER_BASE + reg_addr_t'(ch * 32'd2);
  endfunction

  function automatic reg_addr_t duty_addr(input int unsigned ch);
    return per_addr(ch) + 4'h1;
  endfunction

endpackage

// File: rtl/pwm_ctrl_if.sv
// pwm_ctrl_if: synchronous register port of the PWM controller.
// One write per cycle (wr_en/wr_addr/wr_data); rd_data is a combinational
// function of rd_addr.
interface pwm_ctrl_if;
  import pwm_ctrl_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/pwm_ctrl_prescaler.sv
// pwm_prescaler: shared tick generator. pre_cnt runs 0..prescale while run
// is high; tick pulses in the cycle pre_cnt equals prescale. clr restarts
// the count and suppresses the tick of that cycle.
module pwm_prescaler
  import pwm_ctrl_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             run,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic [PRE_W-1:0] pre_cnt,
  output logic             tick
);

  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] pre_cnt_r;
  logic [PRE_W-1:0] pre_cnt_nxt_s;
  logic             tick_s;

  // Next count and tick: hold at zero when idle or cleared, wrap at prescale.
  always_comb begin
    pre_cnt_nxt_s = pre_cnt_r;
    tick_s        = 1'b0;
    if (!run || clr) begin
      pre_cnt_nxt_s = '0;
    end else if (pre_cnt_r == prescale) begin
      pre_cnt_nxt_s = '0;
      tick_s        = 1'b1;
    end else begin
      pre_cnt_nxt_s = pre_cnt_r + PRE_ONE;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_nxt_s;
    end
  end

  assign pre_cnt = pre_cnt_r;
  assign tick    = tick_s;

endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: NCH-channel PWM controller sharing one prescaler tick.
// Per channel, PERIOD/DUTY shadows are loaded into the active registers at
// each period wrap (or continuously while the channel is disabled).
// Optional feature macro: PWM_CTRL_IRQ_EN (wrap interrupt with W1C status).
module pwm_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic           clk,
  input  logic           RSTn,
  pwm_ctrl_if.slave      bus,
  output logic [NCH-1:0] pwm_out,
  output logic           irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NCH-1:0]       ctrl_r;
  logic [NCH-1:0]       ctrl_nxt_s;
  logic [PRE_W-1:0]     prescale_r;
  logic                 wr_ctrl_s;
  logic                 wr_pre_s;
  logic                 tick_s;
  logic [PRE_W-1:0]     pre_cnt_s;
  logic [NCH-1:0]       wrap_vec_s;
  logic [NCH*CNT_W-1:0] per_sh_flat_s;
  logic [NCH*CNT_W-1:0] duty_sh_flat_s;
  logic [NCH-1:0]       irq_stat_s;
  logic [NCH-1:0]       irq_en_s;
  logic [DATA_W-1:0]    rd_data_s;
  logic                 unused_s;

  assign wr_ctrl_s  = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
  assign wr_pre_s   = bus.wr_en && (bus.wr_addr == ADDR_PRESCALE);
  assign ctrl_nxt_s = wr_ctrl_s ? bus.wr_data[NCH-1:0] : ctrl_r;

  // Global control registers: channel enables and prescale reload value.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      ctrl_r     <= '0;
      prescale_r <= '0;
    end else begin
      ctrl_r <= ctrl_nxt_s;
      if (wr_pre_s) begin
        prescale_r <= bus.wr_data[PRE_W-1:0];
      end else begin
        prescale_r <= prescale_r;
      end
    end
  end

  pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (clk),
    .RSTn     (RSTn),
    .run      (|ctrl_r),
    .clr      (wr_pre_s),
    .prescale (prescale_r),
    .pre_cnt  (pre_cnt_s),
    .tick     (tick_s)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam reg_addr_t PER_A  = per_addr(i);
    localparam reg_addr_t DUTY_A = duty_addr(i);

    logic [CNT_W-1:0] per_sh_r, duty_sh_r, per_act_r, duty_act_r, cnt_r;
    logic [CNT_W-1:0] per_sh_nxt_s, duty_sh_nxt_s;
    logic [CNT_W-1:0] per_act_nxt_s, duty_act_nxt_s, cnt_nxt_s;
    logic             wrap_s;
    logic             pwm_r;

    // Shadow PERIOD/DUTY capture from the register port.
    always_comb begin
      per_sh_nxt_s  = per_sh_r;
      duty_sh_nxt_s = duty_sh_r;
      if (bus.wr_en && (bus.wr_addr == PER_A)) begin
        per_sh_nxt_s = bus.wr_data[CNT_W-1:0];
      end else if (bus.wr_en && (bus.wr_addr == DUTY_A)) begin
        duty_sh_nxt_s = bus.wr_data[CNT_W-1:0];
      end else begin
        per_sh_nxt_s = per_sh_r;
      end
    end

    // Counter and active settings: count on tick, reload old shadows on
    // wrap; a channel that is off (or being switched) sits at zero and
    // tracks its shadows so it restarts cleanly.
    always_comb begin
      cnt_nxt_s      = '0;
      per_act_nxt_s  = per_sh_r;
      duty_act_nxt_s = duty_sh_r;
      wrap_s         = 1'b0;
      if (ctrl_r[i] && ctrl_nxt_s[i]) begin
        cnt_nxt_s      = cnt_r;
        per_act_nxt_s  = per_act_r;
        duty_act_nxt_s = duty_act_r;
        if (tick_s && (cnt_r == per_act_r)) begin
          cnt_nxt_s      = '0;
          per_act_nxt_s  = per_sh_r;
          duty_act_nxt_s = duty_sh_r;
          wrap_s         = 1'b1;
        end else if (tick_s) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end else begin
        cnt_nxt_s = '0;
      end
    end

    // Channel state and output, registered from next-state values.
    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        per_sh_r   <= '0;
        duty_sh_r  <= '0;
        per_act_r  <= '0;
        duty_act_r <= '0;
        cnt_r      <= '0;
        pwm_r      <= 1'b0;
      end else begin
        per_sh_r   <= per_sh_nxt_s;
        duty_sh_r  <= duty_sh_nxt_s;
        per_act_r  <= per_act_nxt_s;
        duty_act_r <= duty_act_nxt_s;
        cnt_r      <= cnt_nxt_s;
        pwm_r      <= ctrl_nxt_s[i] && (cnt_nxt_s < duty_act_nxt_s);
      end
    end

    assign pwm_out[i]                          = pwm_r;
    assign wrap_vec_s[i]                       = wrap_s;
    assign per_sh_flat_s[i*CNT_W +: CNT_W]  = per_sh_r;
    assign duty_sh_flat_s[i*CNT_W +: CNT_W] = duty_sh_r;
  end

`ifdef PWM_CTRL_IRQ_EN
  logic [NCH-1:0] irq_stat_r, irq_stat_nxt_s, irq_en_r, irq_en_nxt_s;
  logic           irq_r;

  // Interrupt status/enable next state; a wrap set wins over a W1C clear.
  always_comb begin
    irq_stat_nxt_s = irq_stat_r;
    irq_en_nxt_s   = irq_en_r;
    if (bus.wr_en && (bus.wr_addr == ADDR_IRQ_STAT)) begin
      irq_stat_nxt_s = irq_stat_r & ~bus.wr_data[NCH-1:0];
    end else if (bus.wr_en && (bus.wr_addr == ADDR_IRQ_EN)) begin
      irq_en_nxt_s = bus.wr_data[NCH-1:0];
    end else begin
      irq_stat_nxt_s = irq_stat_r;
    end
    irq_stat_nxt_s = irq_stat_nxt_s | wrap_vec_s;
  end

  // Interrupt registers and the registered irq line.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      irq_stat_r <= '0;
      irq_en_r   <= '0;
      irq_r      <= 1'b0;
    end else begin
      irq_stat_r <= irq_stat_nxt_s;
      irq_en_r   <= irq_en_nxt_s;
      irq_r      <= |(irq_stat_nxt_s & irq_en_nxt_s);
    end
  end

  assign irq        = irq_r;
  assign irq_stat_s = irq_stat_r;
  assign irq_en_s   = irq_en_r;
  assign unused_s   = ^{bus.wr_data, pre_cnt_s};
`else
  assign irq        = 1'b0;
  assign irq_stat_s = '0;
  assign irq_en_s   = '0;
  assign unused_s   = ^{bus.wr_data, pre_cnt_s, wrap_vec_s};
`endif

  // Read mux: zero-extended register contents, 0 for unmapped addresses.
  always_comb begin
    rd_data_s = '0;
    case (bus.rd_addr)
      ADDR_CTRL:     rd_data_s = DATA_W'(ctrl_r);
      ADDR_PRESCALE: rd_data_s = DATA_W'(prescale_r);
      ADDR_IRQ_STAT: rd_data_s = DATA_W'(irq_stat_s);
      ADDR_IRQ_EN:   rd_data_s = DATA_W'(irq_en_s);
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (bus.rd_addr == per_addr(i)) begin
            rd_data_s = DATA_W'(per_sh_flat_s[i*CNT_W +: CNT_W]);
          end else if (bus.rd_addr == duty_addr(i)) begin
            rd_data_s = DATA_W'(duty_sh_flat_s[i*CNT_W +: CNT_W]);
          end else begin
            rd_data_s = rd_data_s;
          end
        end
      end
    endcase
  end

  assign bus.rd_data = rd_data_s;

endmodule

// File: doc/pwm_ctrl.md
# pwm_ctrl

Multi-channel PWM controller that shares one programmable prescaler tick among NCH independent PWM channels. Each channel has its own period and duty setting, updated glitch-free at period boundaries. It sits on the SoC peripheral side behind a simple synchronous register port and drives pwm_out pins plus an optional interrupt.

## Interface
- NCH, 4: number of PWM channels (1..4).
- CNT_W, 16: channel counter, PERIOD and DUTY width.
- PRE_W, 20: prescaler width.

Ports:
- clk  in  1  system clock.
- RSTn  in  1  reset; asynchronous, active-low.
- wr_en  in  1  register write strobe, one write per cycle.
- wr_addr  in  4  write register index.
- wr_data  in  32  write data; upper bits are ignored.
- rd_addr  in  4  read register index.
- rd_data  out  32  combinational read data, zero-extended; unmapped addresses read 0.
- pwm_out  out  NCH  registered PWM outputs.
- irq  out  1  registered interrupt.

## Operation
- Register map:
  - 0x0 CTRL[NCH-1:0]: channel enables.
  - 0x1 PRESCALE[PRE_W-1:0].
  - 0x2+2*i PERIOD_i.
  - 0x3+2*i DUTY_i.
  - 0xA IRQ_STAT, write-1-to-clear.
  - 0xB IRQ_EN.
- All registers are read/write; PERIOD and DUTY read back their shadow values.
- Prescaler:
  - pre_cnt counts 0..PRESCALE; tick is a one-cycle pulse in the cycle pre_cnt==PRESCALE, after which pre_cnt returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - pre_cnt is held at 0 (no ticks) while CTRL==0.
  - A write to PRESCALE clears pre_cnt and suppresses the tick in that cycle.
- Channel i, enabled:
  - On tick: if cnt_i==per_act_i, then cnt_i←0 (wrap) and load per_act_i/duty_act_i from shadow; else cnt_i←cnt_i+1.
  - Period is PERIOD+1 ticks; output is high for DUTY ticks.
- Channel i, disabled: cnt_i held at 0, active registers copy shadow every cycle, pwm_out[i]=0.
- Output rule: pwm_out[i] ← en_i && (cnt_i_next < duty_act_i_next).
  - DUTY=0: constant low.
  - DUTY>PERIOD: constant high.
- Shadow write in the same cycle as a wrap: the wrap loads the old shadow value; the new value applies at the following wrap.
- Re-enable: the counter starts from 0; the output goes high at the enabling edge if DUTY>0.
- Reset: all registers, counters, pre_cnt, pwm_out and irq are 0.

## Timing
- A register write is visible on rd_data the cycle after the wr_en edge.
- A CTRL write affects pwm_out at that same clock edge (registered from next-state).
- With PRESCALE=P, PERIOD=N and DUTY=D (D≤N): the high time is D*(P+1) clk and the period is (N+1)*(P+1) clk.
- Reset mid-period returns everything to the reset state immediately (asynchronous). Counting resumes only after CTRL is rewritten.

## Configuration
- PWM_CTRL_IRQ_EN defined:
  - IRQ_STAT[i] is set on each wrap of enabled channel i.
  - A W1C clear loses to a simultaneous set.
  - irq ← |(IRQ_STAT & IRQ_EN).
- PWM_CTRL_IRQ_EN undefined: addresses 0xA/0xB read 0, writes to them are ignored, irq is tied 0 (port retained).

## Structure
- Shared package pwm_ctrl_pkg holds the address constants (ADDR_CTRL, ADDR_PRESCALE, ADDR_PER_BASE, ADDR_IRQ_STAT, ADDR_IRQ_EN) and default widths.
- Sub-module pwm_prescaler (pre_cnt, tick, run, clr inputs) is instantiated once.
- Channel logic is a generate loop inside pwm_ctrl.

## Test plan
- Reset behaviour: after reset, all rd_data=0, pwm_out=0, irq=0; enabling a channel with PERIOD=DUTY=0 keeps pwm_out low.
- Basic waveform: PRESCALE=3, PERIOD_0=4, DUTY_0=2, CTRL=1 → pwm_out[0] repeats 8 clk high, 12 clk low (period 20 clk).
- Duty extremes: DUTY_1=0 → constant low; DUTY_1=7 with PERIOD_1=4 → constant high; PRESCALE=0, PERIOD=1, DUTY=1 → 1 clk high, 1 clk low.
- Shadow update: change DUTY_0 from 2 to 4 mid-period → current period keeps 2 high ticks, the next period has 4; a write on the exact wrap cycle applies one period later.
- Disable and reset mid-period: disable a channel mid-high → low at the same edge, counter 0; assert RSTn low mid-period → all outputs 0 asynchronously.
- IRQ (with PWM_CTRL_IRQ_EN): IRQ_EN=1, PERIOD_0=2, PRESCALE=0 → IRQ_STAT[0] set every 3 clk and irq follows; W1C coinciding with a wrap leaves the bit set; without the macro, irq stays 0.
